// File: rtl/atan_sched.sv
// Round-robin scheduler sharing one pipelined atan unit among NREQ requesters.
// A tag pipe tracks each issued vector's owner so its degree returns to that requester.
module atan_sched #(
    parameter int NREQ     = 4,
    parameter int ATAN_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hold,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*10-1:0]   req_x,
    input  logic [NREQ*10-1:0]   req_y,
    output logic [NREQ-1:0]      req_ready,
    output logic [9:0]           atan_x,
    output logic [9:0]           atan_y,
    input  logic [11:0]          atan_degree,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [11:0]          rsp_degree,
    output logic                 busy
);
    localparam int PW     = $clog2(NREQ);
    localparam int STAGES = ATAN_LAT + 1;

    logic [PW-1:0]   rr_ptr_reg;
    logic [PW-1:0]   grant_idx;
    logic            grant_found;
    logic            handshake;
    logic [PW-1:0]   rr_ptr_next;

    logic [9:0]      x_arr [NREQ];
    logic [9:0]      y_arr [NREQ];

    logic [STAGES-1:0] tag_valid_reg;
    logic [PW-1:0]     tag_owner_reg [STAGES];

    logic [9:0]        atan_x_reg;
    logic [9:0]        atan_y_reg;
    logic [NREQ-1:0]   rsp_valid_reg;
    logic [11:0]       rsp_degree_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign x_arr[gi] = req_x[10*gi +: 10];
            assign y_arr[gi] = req_y[10*gi +: 10];
        end
    endgenerate

    // Rotating priority search starting at rr_ptr, wrapping modulo NREQ.
    always_comb begin
        int idx;
        idx         = 0;
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_reg) + k;
            if (idx >= NREQ)
                idx = idx - NREQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = PW'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_found && !hold)
            req_ready = NREQ'(1) << grant_idx;
    end

    assign handshake   = |req_ready;
    assign rr_ptr_next = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + PW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_reg <= '0;
            atan_x_reg <= '0;
            atan_y_reg <= '0;
        end else if (handshake) begin
            rr_ptr_reg <= rr_ptr_next;
            atan_x_reg <= x_arr[grant_idx];
            atan_y_reg <= y_arr[grant_idx];
        end
    end

    // Tag pipe runs freely; hold only gates new grants, never in-flight work.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid_reg[0] <= 1'b0;
            tag_owner_reg[0] <= '0;
        end else begin
            tag_valid_reg[0] <= handshake;
            tag_owner_reg[0] <= grant_idx;
        end
    end

    generate
        for (gi = 1; gi < STAGES; gi++) begin : g_tag
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    tag_valid_reg[gi] <= 1'b0;
                    tag_owner_reg[gi] <= '0;
                end else begin
                    tag_valid_reg[gi] <= tag_valid_reg[gi-1];
                    tag_owner_reg[gi] <= tag_owner_reg[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_reg  <= '0;
            rsp_degree_reg <= '0;
        end else if (tag_valid_reg[STAGES-1]) begin
            rsp_valid_reg  <= NREQ'(1) << tag_owner_reg[STAGES-1];
            rsp_degree_reg <= atan_degree;
        end else begin
            rsp_valid_reg  <= '0;
        end
    end

    assign atan_x     = atan_x_reg;
    assign atan_y     = atan_y_reg;
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_degree = rsp_degree_reg;
    assign busy       = |tag_valid_reg;

endmodule

// File: tb/tb_atan_sched.sv
// Scoreboard bench for atan_sched: stimulus pushes expected responses, a monitor
// pops and checks owner, degree and arrival cycle whenever rsp_valid pulses.
module tb_atan_sched;
    localparam int NREQ = 4;
    localparam int LAT  = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              hold;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*10-1:0] req_x;
    logic [NREQ*10-1:0] req_y;
    logic [NREQ-1:0]   req_ready;
    logic [9:0]        atan_x;
    logic [9:0]        atan_y;
    logic [11:0]       atan_degree;
    logic [NREQ-1:0]   rsp_valid;
    logic [11:0]       rsp_degree;
    logic              busy;

    atan_sched #(.NREQ(NREQ), .ATAN_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .hold(hold),
        .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_ready(req_ready),
        .atan_x(atan_x), .atan_y(atan_y), .atan_degree(atan_degree),
        .rsp_valid(rsp_valid), .rsp_degree(rsp_degree), .busy(busy)
    );

    always #5 clk = ~clk;

    // Vector table with hand-computed atan2(y,x) in whole degrees, 0..359.
    int tx[5]   = '{-48, 48, -48, 48, 0};
    int ty[5]   = '{ 64, 64, -64, -64, 0};
    int tdeg[5] = '{127, 53, 233, 307, 0};

    // Stand-in for the atan unit: recognises the table vectors by value.
    function automatic logic [11:0] atan_ref(input logic signed [9:0] x, input logic signed [9:0] y);
        if (x == -10'sd48 && y ==  10'sd64) return 12'd127;
        if (x ==  10'sd48 && y ==  10'sd64) return 12'd53;
        if (x == -10'sd48 && y == -10'sd64) return 12'd233;
        if (x ==  10'sd48 && y == -10'sd64) return 12'd307;
        if (x ==  10'sd0  && y ==  10'sd0)  return 12'd0;
        return 12'd999;
    endfunction

    logic [11:0] apipe [LAT];
    always @(posedge clk) begin
        apipe[0] <= atan_ref(atan_x, atan_y);
        for (int i = 1; i < LAT; i++)
            apipe[i] <= apipe[i-1];
    end
    assign atan_degree = apipe[LAT-1];

    typedef struct {
        int          owner;
        logic [11:0] deg;
        int          due;
    } exp_t;
    exp_t sbq[$];

    int cyc   = 0;
    int n_vec = 0;
    int n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst !== 1'b1) begin
            if (sbq.size() > 0 && sbq[0].due < cyc) begin
                n_vec++;
                n_bad++;
                $display("FAIL rsp_timeout: owner %0d got nothing, required response by cycle %0d (now %0d)",
                         sbq[0].owner, sbq[0].due, cyc);
                void'(sbq.pop_front());
            end
            if (rsp_valid != '0) begin
                if (sbq.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL rsp_unexpected: got rsp_valid=%b degree=%0d, required no response",
                             rsp_valid, rsp_degree);
                end else begin
                    e = sbq.pop_front();
                    $display("rsp  owner %0d degree %0d cycle %0d", e.owner, rsp_degree, cyc);
                    chk("rsp_owner", 32'(rsp_valid), 32'(1) << e.owner);
                    chk("rsp_degree", 32'(rsp_degree), 32'(e.deg));
                    chk("rsp_latency", 32'(cyc), 32'(e.due));
                end
            end
        end
    end

    // One clock of stimulus: requester i presents table vector (vsel+i)%5.
    task automatic step(input logic [3:0] v, input logic h, input logic [3:0] exp_rdy,
                        input int vsel, input int exp_busy);
        exp_t e;
        int   k;
        hold      = h;
        req_valid = v;
        for (int i = 0; i < NREQ; i++) begin
            k = (vsel + i) % 5;
            req_x[10*i +: 10] = 10'(tx[k]);
            req_y[10*i +: 10] = 10'(ty[k]);
        end
        @(negedge clk);
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (exp_busy >= 0)
            chk("busy", 32'(busy), 32'(exp_busy));
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                k       = (vsel + i) % 5;
                e.owner = i;
                e.deg   = 12'(tdeg[k]);
                e.due   = cyc + LAT + 2;
                sbq.push_back(e);
                $display("issue req %0d x=%0d y=%0d cycle %0d", i, tx[k], ty[k], cyc);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        hold      = 1'b0;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_atan_x", 32'(atan_x), 0);
        chk("reset_atan_y", 32'(atan_y), 0);
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_rsp_degree", 32'(rsp_degree), 0);
        chk("reset_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single request from req 0; busy covers exactly the two in-flight cycles.
        step(4'b0001, 1'b0, 4'b0001, 0, 0);
        step(4'b0000, 1'b0, 4'b0000, 0, 1);
        step(4'b0000, 1'b0, 4'b0000, 0, 1);
        step(4'b0000, 1'b0, 4'b0000, 0, 0);

        // Pointer is at 1; a lone req 3 grant wraps it back to 0.
        step(4'b1000, 1'b0, 4'b1000, 1, -1);

        // Everyone valid: strict rotation 0,1,2,3,0,1,2,3 with back-to-back responses.
        for (int s = 0; s < 8; s++)
            step(4'b1111, 1'b0, 4'(1 << (s % 4)), s, -1);

        // Move pointer to 2, then reqs 1 and 3: 3 first, then wrap to 1.
        step(4'b0010, 1'b0, 4'b0010, 3, -1);
        step(4'b1010, 1'b0, 4'b1000, 0, -1);
        step(4'b1010, 1'b0, 4'b0010, 1, -1);

        // Hold blocks grants but not in-flight returns; pointer stays at 3.
        step(4'b1111, 1'b0, 4'b0100, 2, -1);
        for (int s = 0; s < 3; s++)
            step(4'b1111, 1'b1, 4'b0000, 3, -1);
        step(4'b1111, 1'b0, 4'b1000, 4, -1);
        for (int s = 0; s < 4; s++)
            step(4'b0000, 1'b0, 4'b0000, 0, -1);

        // Reset with two vectors in flight.
        step(4'b1111, 1'b0, 4'b0001, 0, -1);
        step(4'b1111, 1'b0, 4'b0010, 1, -1);
        rst       = 1'b1;
        req_valid = '0;
        #1;
        chk("midrst_atan_x", 32'(atan_x), 0);
        chk("midrst_atan_y", 32'(atan_y), 0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 0);
        chk("midrst_rsp_degree", 32'(rsp_degree), 0);
        chk("midrst_busy", 32'(busy), 0);
        sbq.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++)
            step(4'b0000, 1'b0, 4'b0000, 0, 0);
        step(4'b1111, 1'b0, 4'b0001, 2, -1);
        for (int s = 0; s < 3; s++)
            step(4'b0000, 1'b0, 4'b0000, 0, -1);

        // Every quadrant corner plus origin through every requester.
        for (int r = 0; r < NREQ; r++)
            for (int v = 0; v < 5; v++)
                step(4'(1 << r), 1'b0, 4'(1 << r), (v - r + 5) % 5, -1);
        for (int s = 0; s < 6; s++)
            step(4'b0000, 1'b0, 4'b0000, 0, -1);
        chk("queue_drained", 32'(sbq.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
